// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NOUT packet demultiplexer.
// A single output holding register feeds all channels; only the channel
// latched for the current packet sees out_valid. The destination is taken
// from in_sel on a packet's first beat and held until its last beat.
//
// Optional feature macro: STREAM_DEMUX_DROP_EN
//   defined   : packets whose first-beat in_sel >= NOUT are discarded and
//               reported by a one-cycle pulse on drop.
//   undefined : such packets are clamped to channel NOUT-1; drop is tied 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | between packets; next accepted beat is a first beat
// PKT   | packet in progress, cur_sel locked
// DROP  | discarding an out-of-range packet (STREAM_DEMUX_DROP_EN only)

module stream_demux #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 3,
  parameter int SELW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  input  logic [SELW-1:0]   in_sel,
  output logic [NOUT-1:0]   out_valid,
  input  logic [NOUT-1:0]   out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              drop
);

  // NOUT may equal 2^SELW, so the range compare needs one extra bit.
  localparam logic [SELW:0]   NOUT_X  = (SELW+1)'(NOUT);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NOUT - 1);

`ifdef STREAM_DEMUX_DROP_EN
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
`else
  typedef enum logic [0:0] {IDLE, PKT} state_t;
`endif

  state_t            state_q, state_d;
  logic [SELW-1:0]   cur_sel, cur_sel_d;

  logic              valid_q;
  logic [WIDTH-1:0]  data_q;
  logic              last_q;
  logic [SELW-1:0]   ch_q;

  logic              sel_oor;
  logic [SELW-1:0]   dest;
  logic              discard;
  logic              rdy_sel;
  logic              accept;
  logic              load;

`ifdef STREAM_DEMUX_DROP_EN
  logic              drop_d;
  logic              drop_q;
`endif

  assign sel_oor = {1'b0, in_sel} >= NOUT_X;

  // Ready of the channel currently owning the holding register.
  always_comb begin
    rdy_sel = 1'b0;
    for (int i = 0; i < NOUT; i++) begin
      if (ch_q == SELW'(i)) rdy_sel = out_ready[i];
    end
  end

  // One-hot valid: only the latched channel sees the buffered beat.
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < NOUT; i++) begin
      out_valid[i] = valid_q && (ch_q == SELW'(i));
    end
  end

  // Destination decode: first beats use in_sel, later beats the locked select.
  always_comb begin
    dest    = cur_sel;
    discard = 1'b0;
    if (state_q == IDLE) begin
      dest = sel_oor ? LAST_CH : in_sel;
`ifdef STREAM_DEMUX_DROP_EN
      discard = sel_oor;
`endif
    end
`ifdef STREAM_DEMUX_DROP_EN
    if (state_q == DROP) discard = 1'b1;
`endif
  end

  // Discarded beats bypass the holding register, so they never wait on it.
  assign in_ready = discard || !valid_q || rdy_sel;
  assign accept   = in_valid && in_ready;
  assign load     = accept && !discard;

  assign out_data = data_q;
  assign out_last = last_q;

  // Next-state logic for packet framing and select locking.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel;
`ifdef STREAM_DEMUX_DROP_EN
    drop_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_sel_d = dest;
`ifdef STREAM_DEMUX_DROP_EN
          if (discard) begin
            if (in_last) drop_d  = 1'b1;
            else         state_d = DROP;
          end else if (!in_last) begin
            state_d = PKT;
          end
`else
          if (!in_last) state_d = PKT;
`endif
        end
      end
      PKT: begin
        if (accept && in_last) state_d = IDLE;
      end
`ifdef STREAM_DEMUX_DROP_EN
      DROP: begin
        if (accept && in_last) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and locked-select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_sel <= '0;
    end else begin
      state_q <= state_d;
      cur_sel <= cur_sel_d;
    end
  end

  // Holding register: load on accept, otherwise drain when the owner is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ch_q    <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      last_q  <= in_last;
      ch_q    <= dest;
    end else if (rdy_sel) begin
      valid_q <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_DROP_EN
  // Drop pulse follows the edge that consumed a discarded packet's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= drop_d;
  end

  assign drop = drop_q;
`else
  assign drop = 1'b0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed and randomized checks of stream_demux against a
// packet-level scoreboard. Honors STREAM_DEMUX_DROP_EN like the design.

module tb_stream_demux;

  localparam int WIDTH = 8;
  localparam int NOUT  = 3;
  localparam int SELW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_last = 1'b0;
  logic [SELW-1:0]   in_sel = '0;
  logic [NOUT-1:0]   out_valid;
  logic [NOUT-1:0]   out_ready = '0;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              drop;

  stream_demux #(.WIDTH(WIDTH), .NOUT(NOUT), .SELW(SELW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               ch;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // packet-level model state
  bit   m_in_pkt   = 0;
  bit   m_drop_pkt = 0;
  int   m_ch       = 0;
  bit   exp_drop   = 0;
  bit   held       = 0;
  logic [11:0] held_val;

  // values seen at the last sample point
  logic [NOUT-1:0]  s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             s_in_ready;
  logic             s_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit sel_out_of_range(input logic [SELW-1:0] s);
    return int'(s) >= NOUT;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_in_pkt   = 0;
    m_drop_pkt = 0;
    exp_drop   = 0;
    held       = 0;
  endtask

  // Sample just before the rising edge and score the handshakes about to occur.
  task automatic monitor();
    bit    fire;
    bit    disc;
    bit    exp_rdy;
    beat_t b;
    s_valid    = out_valid;
    s_data     = out_data;
    s_last     = out_last;
    s_in_ready = in_ready;
    s_drop     = drop;

    check("drop", 32'(drop), 32'(exp_drop));
    exp_drop = 0;
    check("onehot", 32'($countones(out_valid) <= 1), 32'd1);
    if (held) check("hold_stable", 32'({out_valid, out_last, out_data}), 32'(held_val));

    fire     = |(out_valid & out_ready);
    held     = (out_valid != '0) && !fire;
    held_val = {out_valid, out_last, out_data};

    disc = 0;
`ifdef STREAM_DEMUX_DROP_EN
    disc = m_in_pkt ? m_drop_pkt : sel_out_of_range(in_sel);
`endif
    exp_rdy = (out_valid == '0) || fire || disc;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));

    if (fire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(out_valid), 32'd0);
      end else begin
        b = exp_q.pop_front();
        check("out_ch",   32'(out_valid), 32'(1 << b.ch));
        check("out_data", 32'(out_data),  32'(b.data));
        check("out_last", 32'(out_last),  32'(b.last));
      end
    end

    if (in_valid && in_ready) begin
      if (!m_in_pkt) begin
        m_drop_pkt = 0;
        if (sel_out_of_range(in_sel)) begin
`ifdef STREAM_DEMUX_DROP_EN
          m_drop_pkt = 1;
`else
          m_ch = NOUT - 1;
`endif
        end else begin
          m_ch = int'(in_sel);
        end
      end
      if (m_drop_pkt) begin
        if (in_last) exp_drop = 1;
      end else begin
        exp_q.push_back('{m_ch, in_data, in_last});
      end
      m_in_pkt = !in_last;
    end
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic l,
                      input logic [SELW-1:0] s, input logic [NOUT-1:0] r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_sel    = s;
    out_ready = r;
    #3;
    monitor();
  endtask

  task automatic expect_out(input string tag, input logic [NOUT-1:0] v,
                            input logic [WIDTH-1:0] d, input logic l);
    check({tag, "_valid"}, 32'(s_valid), 32'(v));
    if (v != '0) begin
      check({tag, "_data"}, 32'(s_data), 32'(d));
      check({tag, "_last"}, 32'(s_last), 32'(l));
    end
  endtask

  initial begin
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_drop",      32'(drop),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // routing with select lock: sel changes to 0 after the first beat
    step(1, 8'h11, 0, 2, 3'b111);
    step(1, 8'h22, 0, 0, 3'b111);  expect_out("route1", 3'b100, 8'h11, 0);
    step(1, 8'h33, 1, 0, 3'b111);  expect_out("route2", 3'b100, 8'h22, 0);
    step(0, 8'h00, 0, 0, 3'b111);  expect_out("route3", 3'b100, 8'h33, 1);
    step(0, 8'h00, 0, 0, 3'b111);  expect_out("route_idle", 3'b000, 8'h00, 0);

    // backpressure on channel 1
    step(1, 8'h5A, 1, 1, 3'b101);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'hA5, 1, 0, 3'b101);
      expect_out("bp_hold", 3'b010, 8'h5A, 1);
      check("bp_in_ready", 32'(s_in_ready), 32'd0);
    end
    step(1, 8'hA5, 1, 0, 3'b111);
    check("bp_release_ready", 32'(s_in_ready), 32'd1);
    step(0, 8'h00, 0, 0, 3'b111);  expect_out("bp_next", 3'b001, 8'hA5, 1);

    // back-to-back single-beat packets
    step(1, 8'h01, 1, 0, 3'b111);
    step(1, 8'h02, 1, 1, 3'b111);  expect_out("b2b0", 3'b001, 8'h01, 1);
    step(0, 8'h00, 0, 0, 3'b111);  expect_out("b2b1", 3'b010, 8'h02, 1);

    // out-of-range select
    step(1, 8'h77, 0, 3, 3'b111);
    step(1, 8'h88, 1, 3, 3'b111);
`ifdef STREAM_DEMUX_DROP_EN
    expect_out("oor0", 3'b000, 8'h00, 0);
    step(0, 8'h00, 0, 0, 3'b111);
    expect_out("oor1", 3'b000, 8'h00, 0);
    check("oor_drop", 32'(s_drop), 32'd1);
    step(0, 8'h00, 0, 0, 3'b111);
    check("oor_drop_end", 32'(s_drop), 32'd0);
`else
    expect_out("oor0", 3'b100, 8'h77, 0);
    step(0, 8'h00, 0, 0, 3'b111);
    expect_out("oor1", 3'b100, 8'h88, 1);
    check("oor_drop", 32'(s_drop), 32'd0);
    step(0, 8'h00, 0, 0, 3'b111);
`endif

    // reset mid-packet clears outputs asynchronously
    step(1, 8'h99, 0, 1, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    model_reset();
    #2;
    rst = 1'b0;
    step(1, 8'h44, 1, 0, 3'b111);
    step(0, 8'h00, 0, 0, 3'b111);  expect_out("post_rst", 3'b001, 8'h44, 1);

    // randomized traffic against the scoreboard
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 3) != 0),
           WIDTH'($urandom),
           logic'($urandom_range(0, 2) == 0),
           SELW'($urandom_range(0, 3)),
           NOUT'($urandom_range(0, 7)));
    end

    // drain
    for (int i = 0; i < 20; i++) begin
      step(0, 8'h00, 0, 0, 3'b111);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(s_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
